uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver; successor to the fixed 8N1 uart_rx.
- Adds configurable baud divisor, data width, parity and stop-bit count.
- Adds an input synchroniser, false-start rejection, parity/framing/overrun error flags, and a valid/ready output holding register.
- Sits between the board RX pin and the byte consumer (command decoder / FIFO).

Parameters:
CLKS_PER_BIT, 100, clk cycles per bit (100 MHz clk, 1 Mbaud); legal range 8..65535
DATA_BITS, 8, payload bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
di  in  1  serial RX line, idle high, asynchronous to clk
do  out  DATA_BITS  received payload; held stable while do_valid=1
done  out  1  one-cycle pulse when a frame completes (good or errored)
do_valid  out  1  holding register full
do_ready  in  1  consumer accepts do when do_valid & do_ready
parity_err  out  1  parity mismatch on the frame currently in do
frame_err  out  1  a stop bit sampled 0 on the frame currently in do
overrun  out  1  sticky; a frame completed while do_valid=1; cleared on accept
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0, do = 0, FSM = IDLE, synchroniser flops = 1.
- di passes through a 2-flop synchroniser; the FSM only sees di_s.
- Bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx counts 0..DATA_BITS-1.
- IDLE: di_s = 0 -> START, cnt = 0.
- START: at cnt = CLKS_PER_BIT/2-1, sample di_s:
  - 0 -> DATA, cnt = 0, idx = 0.
  - 1 -> glitch; return to IDLE with no outputs changed.
- DATA: at cnt = CLKS_PER_BIT-1 (mid-bit), shift di_s into the shift register at bit idx.
  - After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY: sample one mid-bit value; pe = (XOR(data) ^ sample) != (PARITY==1).
- STOP: sample STOP_BITS mid-bit values; fe = any sample 0.
- Frame completion (cycle after the last stop sample):
  - done = 1 for one cycle.
  - If do_valid = 0 or do_ready = 1 in the same cycle: load do, parity_err = pe, frame_err = fe; do_valid = 1.
  - Else: keep old do and flags, set overrun = 1; the new frame is dropped.
- After completion:
  - fe = 0 -> IDLE (allows back-to-back frames: next start edge arrives half a bit later).
  - fe = 1 -> BREAK; wait for di_s = 1, then IDLE.
- Handshake: do_valid & do_ready -> do_valid = 0, overrun = 0 next cycle, unless a completion loads in that same cycle (load wins, overrun stays 0).
- Latency: done rises 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT ± 1 cycles after the di falling edge, where P = (PARITY != 0). Bench tolerance is ±2 cycles.
- Reset mid-frame: immediate abort to IDLE; no done pulse; a partial frame is never presented.
- busy = 1 in START/DATA/PARITY/STOP/BREAK.

Decomposition:
- Package uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
- One sub-module: sync_2ff (generic 2-flop synchroniser, reset value parameter), reused by other pin inputs.
- Counter, shifter, FSM and holding register stay in uart_rx_param.

Test Plan:
1. Default params, 1 µs bits: frames 0x22 then 0x87, each with 20 ns idle gap -> do = 0x22 then 0x87, done once each, no error flags, do_ready held 1.
2. Back-to-back 0x55, 0xAA with zero idle and do_ready = 1 -> both received in order, busy low for ≤ 1 bit time between frames.
3. di low pulse of 300 ns (< half bit) -> no done, FSM back in IDLE, busy low after about 50 cycles.
4. PARITY = 2: send 0x07 with parity bit 0 (wrong) -> do = 0x07, parity_err = 1; resend with parity 1 -> parity_err = 0.
5. Stop bit forced 0 on 0x3C, di held low 5 bit times, then high -> frame_err = 1, stays in BREAK until di high; next frame 0x11 received clean.
6. do_ready = 0: send 0x01, 0x02 -> do = 0x01, overrun = 1; pulse do_ready -> do_valid and overrun clear. Also assert rst_n low mid-DATA -> all outputs 0, no done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes and
// the receive FSM state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bus: payload holding register, status flags and the
// valid/ready handshake. `do` is a reserved word, so the payload is do_data.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] do_data;
    logic                 done;
    logic                 do_valid;
    logic                 do_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output do_data, done, do_valid, parity_err, frame_err, overrun, busy,
        input  do_ready
    );

    modport slave (
        input  do_data, done, do_valid, parity_err, frame_err, overrun, busy,
        output do_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pin inputs. The reset value
// is a parameter so idle-high lines do not look active during reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; only q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised RX line, mid-bit sampling with
// false-start rejection, optional parity, 1 or 2 stop bits, error flags and
// a valid/ready holding register that drops new frames while full.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            di,
    uart_rx_param_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    state_t               state, state_nxt;
    logic                 di_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pe, fe, fin;
    logic                 half_hit, bit_hit, last_stop, cnt_clr;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid, hold_pe, hold_fe, hold_ovr;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (di),
        .q     (di_s)
    );

    assign half_hit = (cnt == HALF_M1);
    assign bit_hit  = (cnt == FULL_M1);
    // START samples at half a bit, so every later full-bit wrap is mid-bit.
    assign cnt_clr  = (state_nxt != state) || bit_hit ||
                      (state == S_IDLE) || (state == S_BREAK);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; last_stop marks the final stop-bit sample.
    always_comb begin
        state_nxt = state;
        last_stop = 1'b0;
        case (state)
            S_IDLE:   if (!di_s) state_nxt = S_START;
            S_START:  if (half_hit) state_nxt = di_s ? S_IDLE : S_DATA;
            S_DATA:   if (bit_hit && idx == LAST_IDX)
                          state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_hit) state_nxt = S_STOP;
            S_STOP: begin
                if (bit_hit && idx == LAST_STOP) begin
                    last_stop = 1'b1;
                    // A low stop bit may be a line break: wait for idle high.
                    state_nxt = (fe || !di_s) ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK:  if (di_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bit-time counter and bit/stop index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state_nxt != state)
                idx <= '0;
            else if (bit_hit && (state == S_DATA || state == S_STOP))
                idx <= idx + IW'(1);
        end
    end

    // Payload shifter, parity/framing accumulation and completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            pe    <= 1'b0;
            fe    <= 1'b0;
            fin   <= 1'b0;
        end else begin
            fin <= last_stop;
            if (state == S_START && state_nxt == S_DATA) begin
                pe <= 1'b0;
                fe <= 1'b0;
            end
            if (state == S_DATA && bit_hit)
                shreg[idx] <= di_s;
            if (state == S_PARITY && bit_hit)
                pe <= (((^shreg) ^ di_s) != (PARITY == PARITY_ODD));
            if (state == S_STOP && bit_hit && !di_s)
                fe <= 1'b1;
        end
    end

    // Holding register: a completing frame loads unless the register is full
    // and not being drained this cycle, in which case it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_pe    <= 1'b0;
            hold_fe    <= 1'b0;
            hold_ovr   <= 1'b0;
        end else if (fin) begin
            if (!hold_valid || rx.do_ready) begin
                hold_data  <= shreg;
                hold_pe    <= pe;
                hold_fe    <= fe;
                hold_valid <= 1'b1;
                hold_ovr   <= 1'b0;
            end else begin
                hold_ovr   <= 1'b1;
            end
        end else if (hold_valid && rx.do_ready) begin
            hold_valid <= 1'b0;
            hold_ovr   <= 1'b0;
        end
    end

    assign rx.do_data    = hold_data;
    assign rx.do_valid   = hold_valid;
    assign rx.parity_err = hold_pe;
    assign rx.frame_err  = hold_fe;
    assign rx.overrun    = hold_ovr;
    assign rx.done       = fin;
    assign rx.busy       = (state != S_IDLE);
endmodule
